aq_djpeg_pixel_wr: RTL and testbench
====================================

# aq_djpeg_pixel_wr

Frame-buffer write stage directly downstream of the YCbCr-to-RGB converter in the JPEG decoder. It accepts pixels with (X,Y) coordinates in MCU/block order and discards MCU padding that falls outside the image. For each remaining pixel it computes a linear frame-buffer byte address, buffers it in a small FIFO, and issues 32-bit write requests on a valid/ready port toward the bus master. It also reports frame completion and overflow status.

## Interface
- FIFO_AW, 4, log2 of FIFO depth (depth 16).
- SKID, 4, free entries reserved for upstream pipeline latency.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- ProcessInit  in  1  start of new image; clears state.
- FrameBase  in  32  byte address of pixel (0,0).
- FrameStride  in  16  bytes per line.
- ImageWidth  in  16  visible width in pixels.
- ImageHeight  in  16  visible height in pixels.
- PixelEnable  in  1  pixel valid (from converter OutEnable).
- PixelX, PixelY  in  16 each  pixel coordinates.
- PixelR, PixelG, PixelB  in  8 each  colour.
- PixelReady  out  1  back-pressure to converter OutReady.
- WrValid  out  1  write request valid.
- WrAddr  out  32  byte address.
- WrData  out  32  {8'h00,R,G,B}.
- WrReady  in  1  write accepted.
- FrameDone  out  1  one-cycle pulse when the last image pixel is written.
- Overflow  out  1  sticky: a pixel arrived while the FIFO was full.
- PixelCount  out  32  pixels written since ProcessInit.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE. ProcessInit enters RUN from any state. RUN moves to DONE on the FrameDone cycle.
- IDLE: PixelReady=0, WrValid=0. Incoming pixels are ignored.
- ProcessInit, every state: flushes the FIFO and pipeline, and clears PixelCount, Overflow and FrameDone. It takes priority over all other events in the same cycle, including a WrValid&&WrReady handshake, whose entry is discarded and not counted.
- RUN acceptance: a pixel is taken on every cycle with PixelEnable=1, with no dependence on PixelReady. The converter pipeline may still deliver up to SKID pixels after PixelReady falls.
- Filter: if PixelX >= ImageWidth or PixelY >= ImageHeight, the pixel is dropped. It takes no FIFO entry and is not counted.
- Stage 1: register the pixel and compute Y*FrameStride, a 16x16 unsigned product giving 32 bits.
- Stage 2: WrAddr = FrameBase + product + {PixelX,2'b00}, all 32-bit, wrapping modulo 2^32. Set last tag = (X==ImageWidth-1 && Y==ImageHeight-1). Push {addr, data, last} into the FIFO.
- Push when full: the entry is dropped and Overflow is set until the next ProcessInit.
- PixelReady = (state==RUN) && (entries in FIFO + in-flight stages <= DEPTH-SKID-2), registered.
- Write port: WrValid = FIFO not empty (RUN or DONE). WrAddr/WrData hold steady while WrValid=1 and WrReady=0. A handshake pops the FIFO and increments PixelCount, wrapping at 2^32.
- FrameDone pulses on the handshake of the last-tagged entry.
- DONE: PixelReady=1 and all incoming pixels are discarded. The FIFO is empty by construction, since the last pixel was written last.
- ImageWidth or ImageHeight of 0: no pixel passes the filter and DONE is never reached.
- Simultaneous push and pop on a full FIFO: the push succeeds and Overflow is not set.

## Timing
- Reset values: PixelReady=0, WrValid=0, WrAddr=0, WrData=0, FrameDone=0, Overflow=0, PixelCount=0, state IDLE.
- Latency: a pixel accepted in cycle n, with the FIFO empty and WrReady=1, shows WrValid=1 in cycle n+3 and is popped at the end of n+3.
- Throughput: one pixel per cycle sustained when WrReady is held at 1.
- PixelReady responds to FIFO level one cycle late; SKID covers this plus the converter latency.
- FrameDone is asserted in the same cycle as the final WrValid&&WrReady; the state is DONE the following cycle.
- Reset mid-frame: all state is lost asynchronously and outputs return to reset values immediately.

## Test plan
- Single pixel: FrameBase=0x1000_0000, Stride=0x0100, X=3, Y=2, RGB=11/22/33, WrReady=1 -> one write, WrAddr=0x1000_020C, WrData=0x0011_2233, 3-cycle latency.
- Padding: width=10, height=8, full 16x8 MCU presented -> exactly 80 writes, PixelCount=80, FrameDone pulses once on the write of (9,7), state DONE.
- Back-pressure: WrReady=0 for 40 cycles with a continuous pixel stream and the upstream stopping 4 cycles after PixelReady falls -> PixelReady=0, no Overflow, 16 entries held. Releasing WrReady drains them in order with addresses unchanged.
- Overflow: ignore PixelReady and push 20 in-image pixels with WrReady=0 -> Overflow=1, PixelCount=16 after drain.
- ProcessInit mid-frame with 5 entries buffered -> next cycle WrValid=0, PixelCount=0, Overflow=0. A new frame then completes normally.
- Async reset asserted while WrValid=1 -> all outputs 0 without a clock edge. After release the block stays in IDLE until ProcessInit.

Source files
------------

// File: rtl/aq_djpeg_pixel_wr_if.sv
// aq_djpeg_pixel_wr_if: pixel input and frame-buffer write request bundle
interface aq_djpeg_pixel_wr_if;
  logic        PixelEnable;
  logic [15:0] PixelX;
  logic [15:0] PixelY;
  logic [7:0]  PixelR;
  logic [7:0]  PixelG;
  logic [7:0]  PixelB;
  logic        PixelReady;
  logic        WrValid;
  logic [31:0] WrAddr;
  logic [31:0] WrData;
  logic        WrReady;
  modport slave (
    input  PixelEnable, PixelX, PixelY, PixelR, PixelG, PixelB, WrReady,
    output PixelReady, WrValid, WrAddr, WrData
  );
  modport master (
    output PixelEnable, PixelX, PixelY, PixelR, PixelG, PixelB, WrReady,
    input  PixelReady, WrValid, WrAddr, WrData
  );
endinterface

// File: rtl/aq_djpeg_pixel_wr.sv
// aq_djpeg_pixel_wr: clips MCU padding, computes frame-buffer addresses and
// streams pixels through a FIFO onto a valid/ready write port.
module aq_djpeg_pixel_wr #(
  parameter int FIFO_AW = 4,
  parameter int SKID    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ProcessInit,
  input  logic [31:0]                FrameBase,
  input  logic [15:0]                FrameStride,
  input  logic [15:0]                ImageWidth,
  input  logic [15:0]                ImageHeight,
  aq_djpeg_pixel_wr_if.slave         px,
  output logic                       FrameDone,
  output logic                       Overflow,
  output logic [31:0]                PixelCount
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int THR   = DEPTH - SKID - 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state_q, state_d;
  logic                 s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [15:0]          s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [23:0]          s1_rgb_q, s1_rgb_d, s2_rgb_q, s2_rgb_d;
  logic [31:0]          s1_prod_q, s1_prod_d, s2_addr_q, s2_addr_d;
  logic                 s2_last_q, s2_last_d;
  logic [56:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [FIFO_AW:0]     cnt_q, cnt_d;
  logic                 ov_q, ov_d, pr_q, pr_d;
  logic [31:0]          pc_q, pc_d;
  logic                 accept, full, pop, push_ok, wr_valid, frame_done;
  logic [FIFO_AW+1:0]   level;
  logic [56:0]          head;
  assign head = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = ProcessInit ? RUN : (state_q == RUN && frame_done) ? DONE : state_q;
  end
  // PixelReady looks at FIFO plus in-flight stages; the skid margin absorbs its one-cycle lag
  always_comb begin
    wr_valid   = (cnt_q != '0) && (state_q != IDLE);
    pop        = wr_valid && px.WrReady;
    frame_done = pop && head[0] && !ProcessInit;
    level      = {1'b0, cnt_q} + (FIFO_AW+2)'(s1_v_q) + (FIFO_AW+2)'(s2_v_q);
    pr_d       = !ProcessInit && (state_q == DONE || (state_q == RUN && level <= (FIFO_AW+2)'(THR)));
  end
  always_comb begin
    accept    = state_q == RUN && px.PixelEnable && px.PixelX < ImageWidth &&
                px.PixelY < ImageHeight && !ProcessInit;
    s1_v_d    = accept;
    s1_x_d    = px.PixelX;
    s1_y_d    = px.PixelY;
    s1_rgb_d  = {px.PixelR, px.PixelG, px.PixelB};
    s1_prod_d = {16'd0, px.PixelY} * {16'd0, FrameStride};
    s2_v_d    = s1_v_q && !ProcessInit;
    s2_addr_d = FrameBase + s1_prod_q + {14'd0, s1_x_q, 2'b00};
    s2_rgb_d  = s1_rgb_q;
    s2_last_d = s1_x_q == ImageWidth - 16'd1 && s1_y_q == ImageHeight - 16'd1;
    full      = cnt_q == (FIFO_AW+1)'(DEPTH);
    push_ok   = s2_v_q && (!full || pop) && !ProcessInit;
    ov_d      = ProcessInit ? 1'b0 : ov_q | (s2_v_q && full && !pop);
    cnt_d     = ProcessInit ? '0 : cnt_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
    rd_d      = ProcessInit ? '0 : rd_q + FIFO_AW'(pop);
    wr_d      = ProcessInit ? '0 : wr_q + FIFO_AW'(push_ok);
    pc_d      = ProcessInit ? '0 : pc_q + 32'(pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_v_q    <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_rgb_q  <= '0;
      s1_prod_q <= '0;
      s2_v_q    <= 1'b0;
      s2_addr_q <= '0;
      s2_rgb_q  <= '0;
      s2_last_q <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      ov_q      <= 1'b0;
      pr_q      <= 1'b0;
      pc_q      <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      s1_rgb_q  <= s1_rgb_d;
      s1_prod_q <= s1_prod_d;
      s2_v_q    <= s2_v_d;
      s2_addr_q <= s2_addr_d;
      s2_rgb_q  <= s2_rgb_d;
      s2_last_q <= s2_last_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      ov_q      <= ov_d;
      pr_q      <= pr_d;
      pc_q      <= pc_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q] <= {s2_addr_q, s2_rgb_q, s2_last_q};
  assign px.PixelReady = pr_q;
  assign px.WrValid    = wr_valid;
  assign px.WrAddr     = wr_valid ? head[56:25] : 32'd0;
  assign px.WrData     = wr_valid ? {8'h00, head[24:1]} : 32'd0;
  assign FrameDone     = frame_done;
  assign Overflow      = ov_q;
  assign PixelCount    = pc_q;
endmodule

// File: tb/tb_aq_djpeg_pixel_wr.sv
// tb_aq_djpeg_pixel_wr: directed scenarios with hand-computed expectations
module tb_aq_djpeg_pixel_wr;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ProcessInit = 1'b0;
  logic [31:0] FrameBase = '0;
  logic [15:0] FrameStride = '0, ImageWidth = 16'd4, ImageHeight = 16'd4;
  logic        FrameDone, Overflow;
  logic [31:0] PixelCount;
  int          vecs = 0, errs = 0;
  aq_djpeg_pixel_wr_if px();
  aq_djpeg_pixel_wr dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .FrameBase(FrameBase),
    .FrameStride(FrameStride), .ImageWidth(ImageWidth), .ImageHeight(ImageHeight),
    .px(px), .FrameDone(FrameDone), .Overflow(Overflow), .PixelCount(PixelCount)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic init_frame(input logic [31:0] base, input logic [15:0] stride, w, h);
    FrameBase = base; FrameStride = stride; ImageWidth = w; ImageHeight = h;
    ProcessInit = 1'b1;
    tick;
    ProcessInit = 1'b0;
  endtask
  task automatic pix(input logic [15:0] x, y, input logic [7:0] r, g, b);
    px.PixelEnable = 1'b1; px.PixelX = x; px.PixelY = y;
    px.PixelR = r; px.PixelG = g; px.PixelB = b;
  endtask
  task automatic test_reset;
    vecs++;
    if ({px.PixelReady, px.WrValid, px.WrAddr, px.WrData, FrameDone, Overflow, PixelCount} !== '0) begin
      errs++; $display("FAIL reset_outputs: got rdy=%b vld=%b addr=%h data=%h fd=%b ov=%b cnt=%0d want all 0",
        px.PixelReady, px.WrValid, px.WrAddr, px.WrData, FrameDone, Overflow, PixelCount);
    end
    @(negedge clk); rst = 1'b1;
    px.WrReady = 1'b1;
    pix(1, 1, 8'h1, 8'h2, 8'h3);
    tick; px.PixelEnable = 1'b0;
    repeat (4) tick;
    vecs++;
    if ({px.PixelReady, px.WrValid, PixelCount} !== '0) begin
      errs++; $display("FAIL idle_ignores: got rdy=%b vld=%b cnt=%0d want 0 0 0", px.PixelReady, px.WrValid, PixelCount);
    end
  endtask
  task automatic test_single;
    px.WrReady = 1'b1;
    init_frame(32'h1000_0000, 16'h0100, 16'd4, 16'd3);
    pix(3, 2, 8'h11, 8'h22, 8'h33);
    tick; px.PixelEnable = 1'b0;
    vecs++;
    if (px.WrValid !== 1'b0) begin errs++; $display("FAIL single_lat1: got vld=%b want 0", px.WrValid); end
    tick;
    vecs++;
    if (px.WrValid !== 1'b0) begin errs++; $display("FAIL single_lat2: got vld=%b want 0", px.WrValid); end
    tick;
    vecs++;
    if ({px.WrValid, px.WrAddr, px.WrData, FrameDone} !== {1'b1, 32'h1000_020C, 32'h0011_2233, 1'b1}) begin
      errs++; $display("FAIL single_write: got vld=%b addr=%h data=%h fd=%b want 1 1000020c 00112233 1",
        px.WrValid, px.WrAddr, px.WrData, FrameDone);
    end
    tick;
    vecs++;
    if ({px.WrValid, FrameDone, PixelCount, px.PixelReady} !== {1'b0, 1'b0, 32'd1, 1'b1}) begin
      errs++; $display("FAIL single_after: got vld=%b fd=%b cnt=%0d rdy=%b want 0 0 1 1",
        px.WrValid, FrameDone, PixelCount, px.PixelReady);
    end
  endtask
  task automatic test_padding;
    int writes = 0, fd = 0;
    px.WrReady = 1'b1;
    init_frame(32'h2000_0000, 16'h0040, 16'd10, 16'd8);
    for (int c = 0; c < 136; c++) begin
      if (px.WrValid) writes++;
      if (FrameDone) begin
        fd++;
        vecs++;
        if (px.WrAddr !== 32'h2000_01E4) begin
          errs++; $display("FAIL pad_last_addr: got %h want 200001e4", px.WrAddr);
        end
      end
      if (c < 128) pix(16'(c % 16), 16'(c / 16), 8'(c), 8'h00, 8'hFF);
      else px.PixelEnable = 1'b0;
      tick;
    end
    vecs++;
    if (writes !== 80 || fd !== 1 || PixelCount !== 32'd80) begin
      errs++; $display("FAIL pad_counts: got writes=%0d fd=%0d cnt=%0d want 80 1 80", writes, fd, PixelCount);
    end
    vecs++;
    if (px.PixelReady !== 1'b1) begin errs++; $display("FAIL pad_done_ready: got %b want 1", px.PixelReady); end
    pix(1, 1, 8'h5, 8'h5, 8'h5);
    tick; px.PixelEnable = 1'b0;
    writes = 0;
    for (int c = 0; c < 5; c++) begin
      if (px.WrValid) writes++;
      tick;
    end
    vecs++;
    if (writes !== 0 || PixelCount !== 32'd80) begin
      errs++; $display("FAIL done_discard: got writes=%0d cnt=%0d want 0 80", writes, PixelCount);
    end
  endtask
  task automatic test_backpressure;
    int extra = 0, n = 0, k = 0;
    px.WrReady = 1'b0;
    init_frame(32'h3000_0000, 16'h0100, 16'd64, 16'd64);
    for (int i = 0; i < 10 && !px.PixelReady; i++) tick;
    vecs++;
    if (px.PixelReady !== 1'b1) begin errs++; $display("FAIL bp_ready_rise: got %b want 1", px.PixelReady); end
    for (int c = 0; c < 40; c++) begin
      if (!px.PixelReady) extra++;
      if (extra <= 4) begin
        pix(16'(n), 0, 8'(n), 8'h00, 8'h00);
        n++;
      end else px.PixelEnable = 1'b0;
      tick;
    end
    px.PixelEnable = 1'b0;
    vecs++;
    if ({px.PixelReady, Overflow, px.WrValid, px.WrAddr} !== {1'b0, 1'b0, 1'b1, 32'h3000_0000}) begin
      errs++; $display("FAIL bp_hold: got rdy=%b ov=%b vld=%b addr=%h want 0 0 1 30000000",
        px.PixelReady, Overflow, px.WrValid, px.WrAddr);
    end
    px.WrReady = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (px.WrValid) begin
        vecs++;
        if (px.WrAddr !== 32'h3000_0000 + 32'(k * 4) || px.WrData !== {8'h00, 8'(k), 16'h0000}) begin
          errs++; $display("FAIL bp_drain[%0d]: got addr=%h data=%h want %h %h", k, px.WrAddr, px.WrData,
            32'h3000_0000 + 32'(k * 4), {8'h00, 8'(k), 16'h0000});
        end
        k++;
      end
      tick;
    end
    vecs++;
    if (k !== 16 || PixelCount !== 32'd16) begin
      errs++; $display("FAIL bp_count: got drained=%0d cnt=%0d want 16 16", k, PixelCount);
    end
  endtask
  task automatic test_overflow;
    px.WrReady = 1'b0;
    init_frame(32'h4000_0000, 16'h0100, 16'd64, 16'd64);
    for (int i = 0; i < 20; i++) begin
      pix(16'(i), 0, 8'(i), 8'h1, 8'h2);
      tick;
    end
    px.PixelEnable = 1'b0;
    repeat (3) tick;
    vecs++;
    if ({Overflow, px.WrValid} !== 2'b11) begin
      errs++; $display("FAIL ovf_set: got ov=%b vld=%b want 1 1", Overflow, px.WrValid);
    end
    px.WrReady = 1'b1;
    repeat (20) tick;
    vecs++;
    if ({Overflow, px.WrValid, PixelCount} !== {1'b1, 1'b0, 32'd16}) begin
      errs++; $display("FAIL ovf_drain: got ov=%b vld=%b cnt=%0d want 1 0 16", Overflow, px.WrValid, PixelCount);
    end
  endtask
  task automatic test_init_midframe;
    int fd = 0;
    px.WrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix(16'(20 + i), 1, 8'h7, 8'h7, 8'h7);
      tick;
    end
    px.PixelEnable = 1'b0;
    repeat (3) tick;
    vecs++;
    if (px.WrValid !== 1'b1) begin errs++; $display("FAIL mid_buffered: got vld=%b want 1", px.WrValid); end
    px.WrReady = 1'b1;
    init_frame(32'h5000_0000, 16'h0010, 16'd2, 16'd1);
    vecs++;
    if ({px.WrValid, PixelCount, Overflow} !== {1'b0, 32'd0, 1'b0}) begin
      errs++; $display("FAIL mid_init_clear: got vld=%b cnt=%0d ov=%b want 0 0 0", px.WrValid, PixelCount, Overflow);
    end
    pix(0, 0, 8'hA, 8'hB, 8'hC);
    tick;
    pix(1, 0, 8'hD, 8'hE, 8'hF);
    tick;
    px.PixelEnable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (FrameDone) begin
        fd++;
        vecs++;
        if (px.WrAddr !== 32'h5000_0004) begin errs++; $display("FAIL mid_new_last: got %h want 50000004", px.WrAddr); end
      end
      tick;
    end
    vecs++;
    if (fd !== 1 || PixelCount !== 32'd2 || px.PixelReady !== 1'b1) begin
      errs++; $display("FAIL mid_new_frame: got fd=%0d cnt=%0d rdy=%b want 1 2 1", fd, PixelCount, px.PixelReady);
    end
  endtask
  task automatic test_zero_size;
    int seen = 0;
    px.WrReady = 1'b1;
    init_frame(32'h0, 16'h0010, 16'd0, 16'd4);
    pix(0, 0, 8'h1, 8'h1, 8'h1);
    tick;
    pix(0, 1, 8'h1, 8'h1, 8'h1);
    tick;
    px.PixelEnable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (px.WrValid) seen++;
      tick;
    end
    vecs++;
    if (seen !== 0 || PixelCount !== 32'd0) begin
      errs++; $display("FAIL zero_width: got writes=%0d cnt=%0d want 0 0", seen, PixelCount);
    end
  endtask
  task automatic test_async_reset;
    int seen = 0;
    px.WrReady = 1'b0;
    init_frame(32'h6000_0000, 16'h0100, 16'd64, 16'd64);
    pix(5, 5, 8'h9, 8'h9, 8'h9);
    tick;
    px.PixelEnable = 1'b0;
    for (int i = 0; i < 6 && !px.WrValid; i++) tick;
    vecs++;
    if (px.WrValid !== 1'b1) begin errs++; $display("FAIL ar_pre: got vld=%b want 1", px.WrValid); end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({px.PixelReady, px.WrValid, px.WrAddr, px.WrData, FrameDone, Overflow, PixelCount} !== '0) begin
      errs++; $display("FAIL ar_outputs: got rdy=%b vld=%b addr=%h data=%h fd=%b ov=%b cnt=%0d want all 0",
        px.PixelReady, px.WrValid, px.WrAddr, px.WrData, FrameDone, Overflow, PixelCount);
    end
    @(negedge clk); rst = 1'b1;
    tick;
    px.WrReady = 1'b1;
    pix(1, 1, 8'h2, 8'h2, 8'h2);
    tick;
    px.PixelEnable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (px.WrValid || px.PixelReady) seen++;
      tick;
    end
    vecs++;
    if (seen !== 0) begin errs++; $display("FAIL ar_idle: got active_cycles=%0d want 0", seen); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
  initial begin
    px.PixelEnable = 1'b0; px.PixelX = '0; px.PixelY = '0;
    px.PixelR = '0; px.PixelG = '0; px.PixelB = '0; px.WrReady = 1'b0;
    #2 rst = 1'b0;
    #3;
    test_reset;
    test_single;
    test_padding;
    test_backpressure;
    test_overflow;
    test_init_midframe;
    test_zero_size;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
